// File: rtl/dmem_req_if.sv
// MEM-stage port of the data-memory request engine: pipeline controls in, stall/misalign out,
// plus the valid/ack memory bus.
interface dmem_req_if;
    // Handshake: o_req rises the cycle after an accepted start and stays high with o_we, o_addr,
    // o_be and o_wdata held stable until a cycle in which i_ack is high. On a read, i_rdata is
    // valid in that ack cycle. o_req is low for at least one cycle before it rises again.
    // i_ack is ignored whenever o_req is low.
    logic        i_valid;
    logic        i_memRead;
    logic        i_memWrite;
    logic        i_isByte;
    logic        i_isHalf;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_stall;
    logic        o_misalign;
    logic        o_req;
    logic        o_we;
    logic [31:0] o_addr;
    logic [3:0]  o_be;
    logic [31:0] o_wdata;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic [31:0] o_rdata;
    logic        o_bus_err;

    modport master (
        input  i_valid, i_memRead, i_memWrite, i_isByte, i_isHalf, i_addr, i_wdata,
        input  i_ack, i_rdata,
        output o_stall, o_misalign, o_req, o_we, o_addr, o_be, o_wdata, o_rdata, o_bus_err
    );

    modport slave (
        output i_valid, i_memRead, i_memWrite, i_isByte, i_isHalf, i_addr, i_wdata,
        output i_ack, i_rdata,
        input  o_stall, o_misalign, o_req, o_we, o_addr, o_be, o_wdata, o_rdata, o_bus_err
    );
endinterface

// File: rtl/dmem_req.sv
// Data-memory request engine: word-aligned load/store requests with byte enables and stall.
// Define DMEM_TIMEOUT_EN to build the WAIT-state timeout; dbg_state: 0=IDLE 1=WAIT 2=RESP.
module dmem_req #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    dmem_req_if.master  bus,
    output logic [1:0]  dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("dmem_req: TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t      state, state_next;
    logic [1:0]  a;
    logic        access, aligned, start, timeout;
    logic        stall, misalign;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic        we_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  be_q;

    assign a      = bus.i_addr[1:0];
    assign access = bus.i_valid & (bus.i_memRead | bus.i_memWrite);
    assign start  = access & aligned;

    // Byte size wins if both size bits are set.
    always_comb begin
        aligned    = 1'b1;
        be_next    = 4'b1111;
        wdata_next = bus.i_wdata;
        if (bus.i_isByte) begin
            be_next    = 4'b0001 << a;
            wdata_next = {4{bus.i_wdata[7:0]}};
        end else if (bus.i_isHalf) begin
            aligned    = ~a[0];
            be_next    = a[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{bus.i_wdata[15:0]}};
        end else begin
            aligned    = (a == 2'b00);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        misalign   = 1'b0;
        case (state)
            IDLE: begin
                misalign = access & ~aligned;
                if (start) begin
                    stall      = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (bus.i_ack | timeout) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            if (state == IDLE && start) begin
                we_q    <= bus.i_memWrite;
                addr_q  <= {bus.i_addr[31:2], 2'b00};
                be_q    <= be_next;
                wdata_q <= wdata_next;
            end
            // A real ack beats a timeout detected in the same cycle.
            if (state == WAIT) begin
                if (bus.i_ack) begin
                    if (!we_q) rdata_q <= bus.i_rdata;
                end else if (timeout) begin
                    rdata_q <= ERR_DATA;
                end
            end
        end
    end

`ifdef DMEM_TIMEOUT_EN
    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_cnt;

    // Counts WAIT cycles already spent without ack; zero on every entry to WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                wait_cnt <= 16'd0;
        else if (state != WAIT)  wait_cnt <= 16'd0;
        else if (!bus.i_ack)     wait_cnt <= wait_cnt + 16'd1;
    end

    assign timeout       = (state == WAIT) & ~bus.i_ack & (wait_cnt == LAST_WAIT);
    assign bus.o_bus_err = timeout;
`else
    assign timeout       = 1'b0;
    assign bus.o_bus_err = 1'b0;
`endif

    assign bus.o_stall    = stall;
    assign bus.o_misalign = misalign;
    assign bus.o_req      = (state == WAIT);
    assign bus.o_we       = we_q;
    assign bus.o_addr     = addr_q;
    assign bus.o_be       = be_q;
    assign bus.o_wdata    = wdata_q;
    assign bus.o_rdata    = rdata_q;
    assign dbg_state      = state;
endmodule

// File: tb/tb_dmem_req.sv
// Directed bench for dmem_req: request-level model with an expected-request queue,
// per-access latency checks and literal pins on the documented vectors.
module tb_dmem_req;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    dmem_req_if bus ();

    int          checks = 0;
    int          errors = 0;
    logic [68:0] exp_q[$];
    logic [31:0] exp_rdata = 32'd0;

    dmem_req #(.TIMEOUT_CYCLES(4), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Request fields {we, addr, be, wdata} derived from access size and byte offset.
    function automatic logic [68:0] model_req(input logic wr, input int size,
                                              input logic [31:0] addr, input logic [31:0] wdata);
        int          off;
        logic [3:0]  be;
        logic [31:0] wd;
        off = int'(addr % 4);
        be  = 4'd0;
        wd  = 32'd0;
        for (int k = 0; k < 4; k++) begin
            if (k >= off && k < off + size) be[k] = 1'b1;
            wd[8*k +: 8] = wdata[8*(k % size) +: 8];
        end
        return {wr, addr - 32'(off), be, wd};
    endfunction

    // Compare process: every cycle a request is outstanding it must match the queue head.
    always @(negedge clk) begin
        if (rst && bus.o_req) begin
            if (exp_q.size() == 0) begin
                check("unexpected_req", 69'(bus.o_req), 69'd0);
            end else begin
                check("req_fields", {bus.o_we, bus.o_addr, bus.o_be, bus.o_wdata}, exp_q[0]);
                if (bus.i_ack || bus.o_bus_err) void'(exp_q.pop_front());
            end
        end
`ifndef DMEM_TIMEOUT_EN
        check("bus_err_tied_low", 69'(bus.o_bus_err), 69'd0);
`endif
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic rd, input logic wr, input logic isb, input logic ish,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.i_valid    = 1'b1;
        bus.i_memRead  = rd;
        bus.i_memWrite = wr;
        bus.i_isByte   = isb;
        bus.i_isHalf   = ish;
        bus.i_addr     = addr;
        bus.i_wdata    = wdata;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.i_valid = 1'b0; bus.i_memRead = 1'b0; bus.i_memWrite = 1'b0; bus.i_ack = 1'b0;
            @(negedge clk);
            check("idle_quiet", {bus.o_stall, bus.o_req, bus.o_misalign}, 69'd0);
        end
    endtask

    // One access; ack arrives in WAIT cycle number ack_wait (>=1). An ack in the start cycle
    // carries junk data and must be ignored. Ends at the RESP negedge with inputs held.
    task automatic do_access(input logic rd, input logic wr, input logic isb, input logic ish,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int ack_wait, input logic [31:0] rdata,
                             input logic pin, input logic [68:0] pin_val);
        int size, stall_cnt, req_cnt;
        size = isb ? 1 : (ish ? 2 : 4);
        @(posedge clk); #1;
        drive(rd, wr, isb, ish, addr, wdata);
        bus.i_ack = 1'b0;
        if (addr % 32'(size) != 0) begin
            @(negedge clk);
            check("misalign_pulse", {bus.o_misalign, bus.o_stall, bus.o_req}, 69'b100);
            @(posedge clk); #1;
            bus.i_valid = 1'b0;
            @(negedge clk);
            check("misalign_one_cycle", {bus.o_misalign, bus.o_stall, bus.o_req, dbg_state}, 69'd0);
            return;
        end
        exp_q.push_back(model_req(wr, size, addr, wdata));
        stall_cnt = 0;
        req_cnt   = 0;
        for (int c = 0; c <= ack_wait + 1; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            bus.i_ack   = (c == ack_wait) || (c == 0);
            bus.i_rdata = (c == ack_wait) ? rdata : $urandom();
            @(negedge clk);
            stall_cnt += int'(bus.o_stall);
            req_cnt   += int'(bus.o_req);
            if (pin && c == 1)
                check("pinned_req", {bus.o_we, bus.o_addr, bus.o_be, bus.o_wdata}, pin_val);
        end
        if (!wr) exp_rdata = rdata;
        check("resp_rdata", 69'(bus.o_rdata), 69'(exp_rdata));
        check("resp_state_stall", {dbg_state, bus.o_stall, bus.o_req}, {ST_RESP, 2'b00});
        check("stall_cycles", 69'(stall_cnt), 69'(ack_wait + 1));
        check("req_cycles", 69'(req_cnt), 69'(ack_wait));
        bus.i_ack = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b0;
        bus.i_valid = 1'b0; bus.i_memRead = 1'b0; bus.i_memWrite = 1'b0;
        bus.i_isByte = 1'b0; bus.i_isHalf = 1'b0; bus.i_addr = 32'd0; bus.i_wdata = 32'd0;
        bus.i_ack = 1'b0; bus.i_rdata = 32'd0;

        @(negedge clk);
        check("reset_req_side", {bus.o_req, bus.o_we, bus.o_be, bus.o_addr, bus.o_wdata}, 69'd0);
        check("reset_misc", {bus.o_rdata, bus.o_misalign, bus.o_bus_err, bus.o_stall, dbg_state},
              {32'd0, 3'b000, 1'b0, ST_IDLE});
        @(posedge clk); #1;
        rst = 1'b1;

        // Byte store at 0x1003, ack in first WAIT cycle.
        do_access(1'b0, 1'b1, 1'b1, 1'b0, 32'h1003, 32'h0000_00A5, 1, 32'h0,
                  1'b1, {1'b1, 32'h1000, 4'b1000, 32'hA5A5_A5A5});
        idle(1);
        // Half load at 0x2002, ack in third WAIT cycle.
        do_access(1'b1, 1'b0, 1'b0, 1'b1, 32'h2002, 32'h0000_BEEF, 3, 32'h1234_5678,
                  1'b1, {1'b0, 32'h2000, 4'b1100, 32'hBEEF_BEEF});
        // Misaligned word load straight after RESP.
        do_access(1'b1, 1'b0, 1'b0, 1'b0, 32'h3001, 32'h0, 1, 32'h0, 1'b0, 69'd0);
        // Read and write both set: the store wins.
        do_access(1'b1, 1'b1, 1'b0, 1'b0, 32'h0040, 32'h1122_3344, 2, 32'h0,
                  1'b1, {1'b1, 32'h0040, 4'b1111, 32'h1122_3344});
        // Back-to-back mix of sizes and offsets.
        do_access(1'b1, 1'b0, 1'b1, 1'b0, 32'h5001, 32'h0, 1, 32'hAABB_CCDD,
                  1'b1, {1'b0, 32'h5000, 4'b0010, 32'h0});
        do_access(1'b0, 1'b1, 1'b0, 1'b1, 32'h5006, 32'h0000_F00D, 2, 32'h0,
                  1'b1, {1'b1, 32'h5004, 4'b1100, 32'hF00D_F00D});
        do_access(1'b0, 1'b1, 1'b0, 1'b1, 32'h5003, 32'h0, 1, 32'h0, 1'b0, 69'd0);
        do_access(1'b0, 1'b1, 1'b1, 1'b0, 32'h5002, 32'h1234_567E, 1, 32'h0,
                  1'b1, {1'b1, 32'h5000, 4'b0100, 32'h7E7E_7E7E});
        do_access(1'b1, 1'b0, 1'b0, 1'b1, 32'h5000, 32'h0000_1357, 1, 32'h5555_0000,
                  1'b1, {1'b0, 32'h5000, 4'b0011, 32'h1357_1357});
        do_access(1'b0, 1'b1, 1'b0, 1'b0, 32'h5008, 32'hCAFE_0001, 2, 32'h0, 1'b0, 69'd0);
        idle(2);

        // Reset asserted in the middle of WAIT aborts the access at once.
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0050, 32'h0);
        exp_q.push_back(model_req(1'b0, 4, 32'h0050, 32'h0));
        @(posedge clk); #1;
        @(negedge clk);
        check("wait_req_high", 69'(bus.o_req), 69'd1);
        #2 rst = 1'b0;
        #1;
        check("async_abort", {bus.o_req, dbg_state}, {1'b0, ST_IDLE});
        exp_q.delete();
        bus.i_valid = 1'b0;
        exp_rdata = 32'd0;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.i_ack = 1'b1;
        bus.i_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("ack_ignored_idle", {bus.o_req, bus.o_stall, dbg_state, bus.o_rdata},
              {1'b0, 1'b0, ST_IDLE, 32'd0});
        @(posedge clk); #1;
        @(negedge clk);
        check("no_resp_after_abort", {dbg_state, bus.o_rdata}, {ST_IDLE, 32'd0});
        idle(1);

`ifdef DMEM_TIMEOUT_EN
        begin
            int err_cnt, err_at, req_cnt;
            err_cnt = 0; err_at = -1; req_cnt = 0;
            @(posedge clk); #1;
            drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0060, 32'h0);
            exp_q.push_back(model_req(1'b0, 4, 32'h0060, 32'h0));
            for (int c = 0; c <= 6; c++) begin
                if (c > 0) begin @(posedge clk); #1; end
                if (c == 6) bus.i_valid = 1'b0;
                @(negedge clk);
                req_cnt += int'(bus.o_req);
                if (bus.o_bus_err) begin err_cnt++; err_at = c; end
                if (c == 5)
                    check("timeout_resp", {dbg_state, bus.o_stall, bus.o_rdata},
                          {ST_RESP, 1'b0, 32'hDEAD_BEEF});
                if (c == 6) check("timeout_back_idle", 69'(dbg_state), 69'(ST_IDLE));
            end
            check("timeout_err_pulses", 69'(err_cnt), 69'd1);
            check("timeout_err_cycle", 69'(err_at), 69'd4);
            check("timeout_req_cycles", 69'(req_cnt), 69'd4);
            exp_rdata = 32'hDEAD_BEEF;
        end
`endif

        do_access(1'b1, 1'b0, 1'b0, 1'b0, 32'h0070, 32'h0, 1, 32'h0F0F_0F0F,
                  1'b1, {1'b0, 32'h0070, 4'b1111, 32'h0});
        idle(2);
        check("queue_drained", 69'(exp_q.size()), 69'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
